// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display scan-out owns the single-port RAM during active video,
// host writes are queued in a small FIFO and drained during blanking.
module vga_fb_arbiter #(
   parameter int HD       = 640,
   parameter int VD       = 480,
   parameter int AW       = 19,
   parameter int DW       = 12,
   parameter int WR_DEPTH = 4
) (
   input  logic          vga_pclk,
   input  logic          vga_rst,
   input  logic          vga_valid,
   input  logic [10:0]   vga_v_cnt,
   input  logic          host_wr_valid,
   output logic          host_wr_ready,
   input  logic [AW-1:0] host_wr_addr,
   input  logic [DW-1:0] host_wr_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          pix_valid,
   output logic [DW-1:0] pix_data,
   output logic          wr_overflow,
   output logic          frame_start
);

   localparam int PW = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(HD * VD - 1);
   localparam logic [10:0]   VD_LINE   = 11'(VD);
   localparam logic [CW-1:0] FULL_CNT  = CW'(WR_DEPTH);

   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             fs_q, fs_d;
   logic             vld_p0_q, vld_p0_d;
   logic             pix_valid_q, pix_valid_d;
   logic [DW-1:0]    pix_data_q, pix_data_d;
   logic [AW+DW-1:0] fifo_mem_q [WR_DEPTH];

   logic vblank, fifo_empty, push, pop;

   assign vblank        = (vga_v_cnt >= VD_LINE);
   assign fifo_empty    = (cnt_q == '0);
   assign host_wr_ready = (cnt_q != FULL_CNT);
   assign push          = host_wr_valid && host_wr_ready;
   assign pop           = !vga_valid && !fifo_empty;

   // Memory port: display read wins whenever vga_valid is high.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (vga_valid) begin
         mem_en   = 1'b1;
         mem_addr = rd_addr_q;
      end else if (!fifo_empty) begin
         mem_en                = 1'b1;
         mem_we                = 1'b1;
         {mem_addr, mem_wdata} = fifo_mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      rd_addr_d = rd_addr_q;
      if (vblank) begin
         rd_addr_d = '0;
      end else if (vga_valid && (rd_addr_q != LAST_ADDR)) begin
         rd_addr_d = rd_addr_q + AW'(1);
      end
      fs_d = vblank && (rd_addr_q != '0);

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q || (host_wr_valid && !host_wr_ready);

      vld_p0_d    = vga_valid;
      pix_valid_d = vld_p0_q;
      pix_data_d  = vld_p0_q ? mem_rdata : '0;
   end

   always_ff @(posedge vga_pclk or negedge vga_rst) begin
      if (!vga_rst) begin
         rd_addr_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         fs_q        <= 1'b0;
         vld_p0_q    <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
      end else begin
         rd_addr_q   <= rd_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         fs_q        <= fs_d;
         vld_p0_q    <= vld_p0_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
      end
   end

   // FIFO storage is only observable through cnt_q, so it needs no reset.
   always_ff @(posedge vga_pclk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {host_wr_addr, host_wr_data};
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign wr_overflow = ovf_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a queue-based reference model,
// using a small frame (8x4) so saturation and frame rewinds happen often.
module tb_vga_fb_arbiter;

   localparam int HD = 8, VD = 4, AW = 9, DW = 12, DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vga_valid = 1'b0;
   logic [10:0]   vga_v_cnt = '0;
   logic          host_wr_valid = 1'b0;
   logic          host_wr_ready;
   logic [AW-1:0] host_wr_addr = '0;
   logic [DW-1:0] host_wr_data = '0;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          wr_overflow, frame_start;

   always #5 clk = ~clk;

   vga_fb_arbiter #(.HD(HD), .VD(VD), .AW(AW), .DW(DW), .WR_DEPTH(DEPTH)) dut (
      .vga_pclk(clk), .vga_rst(rst_n), .vga_valid(vga_valid), .vga_v_cnt(vga_v_cnt),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_data(pix_data),
      .wr_overflow(wr_overflow), .frame_start(frame_start)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           m_q[$];
   int            m_rd;
   bit            m_pv, m_ovf, m_fs, m_vv_last;
   logic [DW-1:0] m_pd;
   int            errors = 0;
   int            checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rd = 0; m_pv = 0; m_pd = '0; m_ovf = 0; m_fs = 0; m_vv_last = 0;
   endtask

   task automatic check_regs();
      chk("pix_valid", 32'(pix_valid), 32'(m_pv));
      chk("pix_data", 32'(pix_data), 32'(m_pd));
      chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
      chk("host_wr_ready", 32'(host_wr_ready), 32'(m_q.size() < DEPTH));
   endtask

   // Called at a negedge: drive one cycle, check the memory port, advance the model,
   // then check the registered outputs at the following negedge.
   task automatic step(input bit vv, input int vc, input bit hv,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                       input logic [DW-1:0] rdata);
      bit rdy;
      vga_valid = vv; vga_v_cnt = 11'(vc); host_wr_valid = hv;
      host_wr_addr = ha; host_wr_data = hd; mem_rdata = rdata;
      #1;
      rdy = (m_q.size() < DEPTH);
      chk("host_wr_ready_pre", 32'(host_wr_ready), 32'(rdy));
      if (vv) begin
         chk("rd_en", 32'(mem_en), 32'd1);
         chk("rd_we", 32'(mem_we), 32'd0);
         chk("rd_addr", 32'(mem_addr), 32'(m_rd));
      end else if (m_q.size() > 0) begin
         chk("wr_en", 32'(mem_en), 32'd1);
         chk("wr_we", 32'(mem_we), 32'd1);
         chk("wr_addr", 32'(mem_addr), 32'(m_q[0].a));
         chk("wr_data", 32'(mem_wdata), 32'(m_q[0].d));
      end else begin
         chk("idle_en", 32'(mem_en), 32'd0);
         chk("idle_we", 32'(mem_we), 32'd0);
         chk("idle_addr", 32'(mem_addr), 32'd0);
         chk("idle_wdata", 32'(mem_wdata), 32'd0);
      end
      if (hv && !rdy) m_ovf = 1;
      m_pv = m_vv_last;
      m_pd = m_vv_last ? rdata : '0;
      m_vv_last = vv;
      m_fs = (vc >= VD) && (m_rd != 0);
      if (vc >= VD) m_rd = 0;
      else if (vv && m_rd < HD * VD - 1) m_rd++;
      if (!vv && m_q.size() > 0) void'(m_q.pop_front());
      if (hv && rdy) m_q.push_back('{a: ha, d: hd});
      @(negedge clk);
      check_regs();
   endtask

   task automatic frame(input int valid_pct, input int host_pct);
      for (int v = 0; v < VD + 2; v++) begin
         for (int h = 0; h < HD + 4; h++) begin
            bit vv;
            vv = (v < VD) && (h < HD) && ($urandom_range(99) < valid_pct);
            step(vv, v, $urandom_range(99) < host_pct, AW'($urandom), DW'($urandom),
                 DW'($urandom));
         end
      end
   endtask

   initial begin
      model_reset();
      #1;
      check_regs();
      chk("reset_mem_en", 32'(mem_en), 32'd0);
      chk("reset_mem_we", 32'(mem_we), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Four display reads while the host fills the FIFO, then a refused fifth write.
      for (int i = 0; i < 4; i++) step(1, 0, 1, AW'(9'h100 + i), DW'(12'hA5A + i), DW'($urandom));
      step(1, 0, 1, AW'(9'h1FF), DW'(12'hFFF), DW'($urandom));
      for (int i = 0; i < 6; i++) step(0, 0, 0, '0, '0, DW'($urandom));

      // Push and pop in the same cycle with two entries queued.
      step(1, 1, 1, AW'(9'h010), DW'(12'h001), DW'($urandom));
      step(1, 1, 1, AW'(9'h011), DW'(12'h002), DW'($urandom));
      step(0, 1, 1, AW'(9'h012), DW'(12'h003), DW'($urandom));
      for (int i = 0; i < 4; i++) step(0, 1, 0, '0, '0, DW'($urandom));

      // Complete frames with full active video, then sparse and saturating ones.
      frame(100, 30);
      frame(100, 30);
      frame(70, 50);

      // Reset while draining three queued writes.
      for (int i = 0; i < 4; i++) step(1, 2, 1, AW'(9'h040 + i), DW'(12'h300 + i), DW'($urandom));
      step(0, 2, 0, '0, '0, DW'($urandom));
      vga_valid = 1'b0; host_wr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_regs();
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_we", 32'(mem_we), 32'd0);
      chk("rst_hold_ready", 32'(host_wr_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 5, 0, '0, '0, DW'($urandom));
      step(0, 5, 0, '0, '0, DW'($urandom));

      for (int f = 0; f < 8; f++) frame(60 + 5 * f, 20 + 10 * (f % 4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous pixel memory between display scan-out and a host write port.
- Sits between the vga timing generator (consumes its vga_valid and vga_v_cnt) and the frame-buffer RAM.
- Display reads have absolute priority during active video.
- Host writes are posted into a small FIFO and drained only while vga_valid is low, so scan-out never stalls or tears mid-pixel.

Parameters:
- HD, 640, active pixels per line.
- VD, 480, active lines per frame.
- AW, 19, memory address width; must satisfy 2^AW >= HD*VD.
- DW, 12, pixel width (RGB444).
- WR_DEPTH, 4, host write FIFO depth; power of two, >= 2.

Ports:
- vga_pclk  in  1  pixel clock; all logic is on its rising edge.
- vga_rst  in  1  asynchronous, active-low reset.
- vga_valid  in  1  active-video flag from the timing generator.
- vga_v_cnt  in  11  line counter from the timing generator.
- host_wr_valid  in  1  host write request.
- host_wr_ready  out  1  FIFO can accept a write; equals !full.
- host_wr_addr  in  AW  linear pixel address (line*HD + pixel).
- host_wr_data  in  DW  pixel value.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable; only valid with mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, one cycle after a read access.
- pix_valid  out  1  pix_data is an active pixel.
- pix_data  out  DW  scan-out pixel; 0 when pix_valid is 0.
- wr_overflow  out  1  sticky flag: host_wr_valid was high while host_wr_ready was low.
- frame_start  out  1  one-cycle pulse when the read address rewinds to 0.

Behaviour:
- Reset (vga_rst=0, async), all registers clear:
  - rd_addr=0; FIFO empty, so host_wr_ready=1.
  - pix_valid=0, pix_data=0, wr_overflow=0, frame_start=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation discards any queued writes.
- Read address counter rd_addr:
  - Increments by 1 on every cycle with vga_valid=1.
  - Set to 0 on every cycle with vga_v_cnt >= VD (vertical blank).
  - frame_start pulses high for one cycle on the first vblank cycle in which rd_addr was non-zero.
  - rd_addr saturates at HD*VD-1 and never wraps past the frame.
- Arbitration is combinational from registered state; mem_* are combinational outputs.
  - vga_valid=1: mem_en=1, mem_we=0, mem_addr=rd_addr. Display read.
  - vga_valid=0 and FIFO not empty: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head; pop head this cycle.
  - Otherwise: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Pixel pipeline has a fixed 2-cycle latency from vga_valid:
  - A read in cycle t returns mem_rdata in t+1.
  - It is registered into pix_data with pix_valid=1 at t+2.
  - If vga_valid was 0 in cycle t, then at t+2 pix_valid=0 and pix_data=0.
  - Downstream delays hsync/vsync by 2 to match.
- Write FIFO:
  - Push when host_wr_valid && host_wr_ready.
  - Simultaneous push and pop is allowed in any state, including full: ready reflects the registered count, so a push while full is refused even if a pop occurs.
  - Occupancy count is log2(WR_DEPTH)+1 bits.
- wr_overflow:
  - Sets on host_wr_valid && !host_wr_ready.
  - Clears only on reset.
- Host writes never reach memory during active video; worst-case drain starts at the next blanking cycle.
- A host write to the address currently being read is allowed; the display sees old data until the next frame.

Test Plan:
- Reset release, then vga_valid high for 4 cycles starting at rd_addr 0 -> mem_addr 0,1,2,3 with mem_we=0; pix_valid high 2 cycles later for 4 cycles; pix_data = mem_rdata values.
- Host posts 4 writes during active video (addr 0x100..0x103, data 0xA5A..0xA5D) -> host_wr_ready drops after the 4th; zero mem_we during active; 4 consecutive write cycles at the first vga_valid=0 cycles, in order.
- 5th write while full -> refused, wr_overflow=1 and remains 1 until reset.
- Push and pop in the same cycle with FIFO at 2 entries -> occupancy stays 2, order preserved.
- vga_v_cnt steps to 480 after a full frame -> rd_addr=0, single frame_start pulse; next frame's first read at mem_addr 0.
- Assert vga_rst low mid-drain with 3 entries queued -> all outputs 0 immediately (async), host_wr_ready=1, no further mem_we.
